// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-64 encodings (icodes, stats, RNONE), run-state codes and FSM state type
// for the pipeline control block.
package pipe_ctrl_pkg;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    localparam logic [1:0] RS_RUN    = 2'd0;
    localparam logic [1:0] RS_DRAIN  = 2'd1;
    localparam logic [1:0] RS_HALTED = 2'd2;
    localparam logic [1:0] RS_EXC    = 2'd3;

    typedef enum logic [2:0] {
        StRun,
        StDrain,
        StHalted,
        StStep,
        StExc
    } run_st_e;

    function automatic logic is_fault(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load/use, ret, mispredict and exception terms
// for the five-stage Y86-64 pipeline.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] i_D_icode,
    input  logic [3:0] i_d_srcA,
    input  logic [3:0] i_d_srcB,
    input  logic [3:0] i_E_icode,
    input  logic [3:0] i_E_dstM,
    input  logic       i_e_Cnd,
    input  logic [3:0] i_M_icode,
    input  logic [2:0] i_m_stat,
    input  logic [2:0] i_W_stat,
    output logic       o_lu,
    output logic       o_ret,
    output logic       o_mp,
    output logic       o_exc,
    output logic       o_w_fault
);

    logic w_e_load;

    assign w_e_load  = (i_E_icode == IMRMOVQ) || (i_E_icode == IPOPQ);
    // RNONE must never alias a register read, even if srcA/srcB also carry RNONE.
    assign o_lu      = w_e_load && (i_E_dstM != RNONE) &&
                       ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
    assign o_ret     = (i_D_icode == IRET) || (i_E_icode == IRET) || (i_M_icode == IRET);
    assign o_mp      = (i_E_icode == IJXX) && !i_e_Cnd;
    assign o_w_fault = is_fault(i_W_stat);
    assign o_exc     = is_fault(i_m_stat) || o_w_fault;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 stall/bubble strobes, debug run/halt/step FSM and retire counter.
// Define PIPE_PERF_CNT_EN to build the cycle, load/use and mispredict counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic [2:0]       W_stat_i,
    input  logic             dbg_halt_i,
    input  logic             dbg_step_i,
    input  logic             dbg_resume_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic [1:0]       run_state_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] mp_cnt_o
);

    logic             w_lu;
    logic             w_ret;
    logic             w_mp;
    logic             w_exc;
    logic             w_w_fault;
    logic             w_fz;
    logic             w_pipe_empty;
    logic             w_retire;
    run_st_e          r_state;
    run_st_e          w_state_nxt;
    logic [CNT_W-1:0] r_retire_cnt;

    hazard_detect u_hazard_detect (
        .i_D_icode (D_icode_i),
        .i_d_srcA  (d_srcA_i),
        .i_d_srcB  (d_srcB_i),
        .i_E_icode (E_icode_i),
        .i_E_dstM  (E_dstM_i),
        .i_e_Cnd   (e_Cnd_i),
        .i_M_icode (M_icode_i),
        .i_m_stat  (m_stat_i),
        .i_W_stat  (W_stat_i),
        .o_lu      (w_lu),
        .o_ret     (w_ret),
        .o_mp      (w_mp),
        .o_exc     (w_exc),
        .o_w_fault (w_w_fault)
    );

    // STEP is the one frozen-mode cycle that lets a single fetch through.
    assign w_fz = (r_state == StDrain) || (r_state == StHalted) || (r_state == StExc);

    // lu and mp both decode E_icode exclusively, so D_stall and D_bubble never collide.
    assign F_stall_o  = w_lu | w_ret | w_fz;
    assign D_stall_o  = w_lu;
    assign D_bubble_o = w_mp | (!w_lu & (w_ret | w_fz));
    assign E_bubble_o = w_mp | w_lu;
    assign M_bubble_o = w_exc;
    assign W_stall_o  = w_w_fault;

    assign w_pipe_empty = (D_icode_i == INOP) && (E_icode_i == INOP) && (M_icode_i == INOP)
                          && !w_lu;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:    if (dbg_halt_i) w_state_nxt = StDrain;
            StDrain:  if (w_pipe_empty) w_state_nxt = StHalted;
            StHalted: begin
                if (dbg_resume_i) begin
                    w_state_nxt = StRun;
                end else if (dbg_step_i) begin
                    w_state_nxt = StStep;
                end
            end
            StStep:   w_state_nxt = StDrain;
            StExc:    w_state_nxt = StExc;
            default:  w_state_nxt = StRun;
        endcase
        if (W_stat_i != SAOK) begin
            w_state_nxt = StExc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        run_state_o = RS_RUN;
        case (r_state)
            StRun:    run_state_o = RS_RUN;
            StDrain:  run_state_o = RS_DRAIN;
            StStep:   run_state_o = RS_DRAIN;
            StHalted: run_state_o = RS_HALTED;
            StExc:    run_state_o = RS_EXC;
            default:  run_state_o = RS_RUN;
        endcase
    end

    assign halted_o = (r_state == StHalted);

    assign w_retire = (W_icode_i != INOP) && (W_stat_i == SAOK) && !w_w_fault;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt_o = r_retire_cnt;

`ifdef PIPE_PERF_CNT_EN
    logic             w_active;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mp_cnt;

    assign w_active = (r_state == StRun) || (r_state == StDrain) || (r_state == StStep);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle_cnt <= '0;
            r_lu_cnt    <= '0;
            r_mp_cnt    <= '0;
        end else begin
            if (w_active) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_lu)     r_lu_cnt    <= r_lu_cnt + CNT_W'(1);
            if (w_mp)     r_mp_cnt    <= r_mp_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt_o = r_cycle_cnt;
    assign lu_cnt_o    = r_lu_cnt;
    assign mp_cnt_o    = r_mp_cnt;
`else
    assign cycle_cnt_o = '0;
    assign lu_cnt_o    = '0;
    assign mp_cnt_o    = '0;
`endif

endmodule
